// File: rtl/vic_pkg.sv
// Shared register indices, IRQ bit positions and read-back fill masks
// for the VIC-II CPU register responder.
package vic_pkg;

   localparam logic [5:0] REG_SPR0_X   = 6'h00;
   localparam logic [5:0] REG_SPR_XMSB = 6'h10;
   localparam logic [5:0] REG_CTRL1    = 6'h11;
   localparam logic [5:0] REG_RASTER   = 6'h12;
   localparam logic [5:0] REG_LPX      = 6'h13;
   localparam logic [5:0] REG_LPY      = 6'h14;
   localparam logic [5:0] REG_SPR_EN   = 6'h15;
   localparam logic [5:0] REG_CTRL2    = 6'h16;
   localparam logic [5:0] REG_SPR_YEXP = 6'h17;
   localparam logic [5:0] REG_MEM_PTR  = 6'h18;
   localparam logic [5:0] REG_IRQ      = 6'h19;
   localparam logic [5:0] REG_IRQ_EN   = 6'h1A;
   localparam logic [5:0] REG_SPR_PRIO = 6'h1B;
   localparam logic [5:0] REG_SPR_MC   = 6'h1C;
   localparam logic [5:0] REG_SPR_XEXP = 6'h1D;
   localparam logic [5:0] REG_SS_COLL  = 6'h1E;
   localparam logic [5:0] REG_SB_COLL  = 6'h1F;
   localparam logic [5:0] REG_BORDER   = 6'h20;
   localparam logic [5:0] REG_BG0      = 6'h21;
   localparam logic [5:0] REG_SPR_MC0  = 6'h25;
   localparam logic [5:0] REG_SPR_MC1  = 6'h26;
   localparam logic [5:0] REG_SPR0_COL = 6'h27;
   localparam logic [5:0] REG_SPR7_COL = 6'h2E;

   localparam int unsigned IRQ_RST = 0;
   localparam int unsigned IRQ_MBC = 1;
   localparam int unsigned IRQ_MMC = 2;
   localparam int unsigned IRQ_LP  = 3;

   localparam logic [7:0] MASK_CTRL2   = 8'hC0;
   localparam logic [7:0] MASK_MEM_PTR = 8'h01;
   localparam logic [7:0] MASK_IRQ     = 8'h70;
   localparam logic [7:0] MASK_IRQ_EN  = 8'hF0;
   localparam logic [7:0] MASK_COLOR   = 8'hF0;
   localparam logic [7:0] MASK_UNUSED  = 8'hFF;

   // Bits that read as 1 regardless of stored contents.
   function automatic logic [7:0] rd_or_mask(input logic [5:0] a);
      logic [7:0] m;
      m = '0;
      if (a > REG_SPR7_COL)
         m = MASK_UNUSED;
      else if (a >= REG_BORDER)
         m = MASK_COLOR;
      else
         case (a)
            REG_CTRL2:   m = MASK_CTRL2;
            REG_MEM_PTR: m = MASK_MEM_PTR;
            REG_IRQ:     m = MASK_IRQ;
            REG_IRQ_EN:  m = MASK_IRQ_EN;
            default:     m = '0;
         endcase
      return m;
   endfunction

   // Plain storage registers; IRQ, light-pen and collision registers live elsewhere.
   function automatic logic is_storage(input logic [5:0] a);
      return (a <= REG_RASTER) ||
             (a >= REG_SPR_EN   && a <= REG_MEM_PTR) ||
             (a >= REG_SPR_PRIO && a <= REG_SPR_XEXP) ||
             (a >= REG_BORDER   && a <= REG_SPR7_COL);
   endfunction

endpackage

// File: rtl/vic_irq_ctrl.sv
// Interrupt latch ($19), enable register ($1A), collision first-hit
// detection and the registered active-low CPU IRQ line.
module vic_irq_ctrl
   import vic_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       i_we_latch,
   input  logic       i_we_en,
   input  logic [3:0] i_wdata,
   input  logic       i_rst_hit,
   input  logic       i_lp_hit,
   input  logic [7:0] i_ss_cur,
   input  logic [7:0] i_ss_hit,
   input  logic [7:0] i_sb_cur,
   input  logic [7:0] i_sb_hit,
   output logic [3:0] o_latch,
   output logic [3:0] o_en,
   output logic       o_irq,
   output logic       o_irq_n
);

   logic [3:0] r_latch;
   logic [3:0] r_en;
   logic       r_irq_n;
   logic [3:0] w_set;
   logic [3:0] w_clr;
   logic [3:0] w_latch_nxt;
   logic [3:0] w_en_nxt;

   // An empty collision register receiving any hit becomes nonzero whether or not it is being read.
   always_comb begin
      w_set          = '0;
      w_set[IRQ_RST] = i_rst_hit;
      w_set[IRQ_MBC] = (i_sb_cur == '0) && (i_sb_hit != '0);
      w_set[IRQ_MMC] = (i_ss_cur == '0) && (i_ss_hit != '0);
      w_set[IRQ_LP]  = i_lp_hit;
      w_clr          = i_we_latch ? i_wdata : '0;
      w_latch_nxt    = (r_latch & ~w_clr) | w_set;
      w_en_nxt       = i_we_en ? i_wdata : r_en;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_latch <= '0;
         r_en    <= '0;
         r_irq_n <= 1'b1;
      end else begin
         r_latch <= w_latch_nxt;
         r_en    <= w_en_nxt;
         r_irq_n <= ~|(w_latch_nxt & w_en_nxt);
      end
   end

   assign o_latch = r_latch;
   assign o_en    = r_en;
   assign o_irq   = |(r_latch & r_en);
   assign o_irq_n = r_irq_n;

endmodule

// File: rtl/vic_reg_file.sv
// VIC-II CPU register responder: $D000-$D03F storage, read-back with
// unused-bit fill, collision and light-pen latches, IRQ generation.
module vic_reg_file
   import vic_pkg::*;
#(
   parameter int unsigned NUM_SPR           = 8,
   parameter bit          LP_ONCE_PER_FRAME = 1'b1
)(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i_bus_ce,
   input  logic                   i_cs,
   input  logic                   i_rw,
   input  logic [5:0]             i_addr,
   input  logic [7:0]             i_data,
   output logic [7:0]             o_data,
   input  logic [8:0]             i_raster_y,
   input  logic                   i_line_start,
   input  logic                   i_frame_start,
   input  logic [NUM_SPR-1:0]     i_spr_spr_hit,
   input  logic [NUM_SPR-1:0]     i_spr_bg_hit,
   input  logic                   i_lp_trig,
   input  logic [7:0]             i_lp_x,
   output logic                   o_irq_n,
   output logic [6:0]             o_ctrl1,
   output logic [8:0]             o_raster_cmp,
   output logic [5:0]             o_ctrl2,
   output logic [6:0]             o_mem_ptr,
   output logic [9*NUM_SPR-1:0]   o_spr_x,
   output logic [8*NUM_SPR-1:0]   o_spr_y,
   output logic [NUM_SPR-1:0]     o_spr_en,
   output logic [NUM_SPR-1:0]     o_spr_yexp,
   output logic [NUM_SPR-1:0]     o_spr_prio,
   output logic [NUM_SPR-1:0]     o_spr_mc,
   output logic [NUM_SPR-1:0]     o_spr_xexp,
   output logic [3:0]             o_border,
   output logic [15:0]            o_bg,
   output logic [3:0]             o_spr_mc0,
   output logic [3:0]             o_spr_mc1,
   output logic [4*NUM_SPR-1:0]   o_spr_col
);

   logic [7:0] r_reg [64];
   logic [7:0] r_ss;
   logic [7:0] r_sb;
   logic [7:0] r_lpx;
   logic [7:0] r_lpy;
   logic       r_lp_armed;
   logic [7:0] r_data;

   logic       w_wr;
   logic       w_rd;
   logic [8:0] w_cmp;
   logic       w_rst_hit;
   logic       w_lp_latch;
   logic [7:0] w_ss_nxt;
   logic [7:0] w_sb_nxt;
   logic [7:0] w_rd_base;
   logic [3:0] w_latch;
   logic [3:0] w_en;
   logic       w_irq;

   assign w_wr  = i_bus_ce & i_cs & ~i_rw;
   assign w_rd  = i_bus_ce & i_cs & i_rw;
   assign w_cmp = {r_reg[REG_CTRL1][7], r_reg[REG_RASTER]};

   // Compare match from either a new raster line or a compare write landing on the current line.
   always_comb begin
      w_rst_hit = i_line_start && (i_raster_y == w_cmp);
      if (w_wr && i_addr == REG_CTRL1 && {i_data[7], r_reg[REG_RASTER]} == i_raster_y)
         w_rst_hit = 1'b1;
      if (w_wr && i_addr == REG_RASTER && {r_reg[REG_CTRL1][7], i_data} == i_raster_y)
         w_rst_hit = 1'b1;
   end

   assign w_lp_latch = i_lp_trig & (r_lp_armed | i_frame_start);
   assign w_ss_nxt   = ((w_rd && i_addr == REG_SS_COLL) ? 8'h00 : r_ss) | i_spr_spr_hit;
   assign w_sb_nxt   = ((w_rd && i_addr == REG_SB_COLL) ? 8'h00 : r_sb) | i_spr_bg_hit;

   vic_irq_ctrl u_irq (
      .clk        (clk),
      .reset      (reset),
      .i_we_latch (w_wr && i_addr == REG_IRQ),
      .i_we_en    (w_wr && i_addr == REG_IRQ_EN),
      .i_wdata    (i_data[3:0]),
      .i_rst_hit  (w_rst_hit),
      .i_lp_hit   (w_lp_latch),
      .i_ss_cur   (r_ss),
      .i_ss_hit   (i_spr_spr_hit),
      .i_sb_cur   (r_sb),
      .i_sb_hit   (i_spr_bg_hit),
      .o_latch    (w_latch),
      .o_en       (w_en),
      .o_irq      (w_irq),
      .o_irq_n    (o_irq_n)
   );

   always_comb begin
      case (i_addr)
         REG_CTRL1:   w_rd_base = {i_raster_y[8], r_reg[REG_CTRL1][6:0]};
         REG_RASTER:  w_rd_base = i_raster_y[7:0];
         REG_LPX:     w_rd_base = r_lpx;
         REG_LPY:     w_rd_base = r_lpy;
         REG_IRQ:     w_rd_base = {w_irq, 3'b000, w_latch};
         REG_IRQ_EN:  w_rd_base = {4'h0, w_en};
         REG_SS_COLL: w_rd_base = r_ss;
         REG_SB_COLL: w_rd_base = r_sb;
         default:     w_rd_base = r_reg[i_addr];
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < 64; i++)
            r_reg[i] <= '0;
         r_ss       <= '0;
         r_sb       <= '0;
         r_lpx      <= '0;
         r_lpy      <= '0;
         r_lp_armed <= 1'b1;
         r_data     <= '0;
      end else begin
         if (w_wr && is_storage(i_addr))
            r_reg[i_addr] <= i_data;
         if (w_rd)
            r_data <= w_rd_base | rd_or_mask(i_addr);
         r_ss <= w_ss_nxt;
         r_sb <= w_sb_nxt;
         // Frame start re-arms before a same-cycle trigger is considered.
         if (w_lp_latch) begin
            r_lpx      <= i_lp_x;
            r_lpy      <= i_raster_y[7:0];
            r_lp_armed <= !LP_ONCE_PER_FRAME;
         end else if (i_frame_start) begin
            r_lp_armed <= 1'b1;
         end
      end
   end

   assign o_data       = r_data;
   assign o_ctrl1      = r_reg[REG_CTRL1][6:0];
   assign o_raster_cmp = w_cmp;
   assign o_ctrl2      = r_reg[REG_CTRL2][5:0];
   assign o_mem_ptr    = r_reg[REG_MEM_PTR][7:1];
   assign o_spr_en     = r_reg[REG_SPR_EN];
   assign o_spr_yexp   = r_reg[REG_SPR_YEXP];
   assign o_spr_prio   = r_reg[REG_SPR_PRIO];
   assign o_spr_mc     = r_reg[REG_SPR_MC];
   assign o_spr_xexp   = r_reg[REG_SPR_XEXP];
   assign o_border     = r_reg[REG_BORDER][3:0];
   assign o_spr_mc0    = r_reg[REG_SPR_MC0][3:0];
   assign o_spr_mc1    = r_reg[REG_SPR_MC1][3:0];

   always_comb begin
      o_spr_x   = '0;
      o_spr_y   = '0;
      o_spr_col = '0;
      o_bg      = '0;
      for (int unsigned n = 0; n < NUM_SPR; n++) begin
         o_spr_x[9*n +: 9]   = {r_reg[REG_SPR_XMSB][n], r_reg[6'(REG_SPR0_X + 2*n)]};
         o_spr_y[8*n +: 8]   = r_reg[6'(REG_SPR0_X + 2*n + 1)];
         o_spr_col[4*n +: 4] = r_reg[6'(REG_SPR0_COL + n)][3:0];
      end
      for (int unsigned n = 0; n < 4; n++)
         o_bg[4*n +: 4] = r_reg[6'(REG_BG0 + n)][3:0];
   end

endmodule

// File: tb/tb_vic_reg_file.sv
// Randomized self-checking bench for vic_reg_file against a byte-level
// behavioural model, plus directed literal checks of the key scenarios.
module tb_vic_reg_file;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        i_bus_ce = 1'b0, i_cs = 1'b0, i_rw = 1'b0;
   logic [5:0]  i_addr = '0;
   logic [7:0]  i_data = '0;
   logic [7:0]  o_data;
   logic [8:0]  i_raster_y = '0;
   logic        i_line_start = 1'b0, i_frame_start = 1'b0, i_lp_trig = 1'b0;
   logic [7:0]  i_spr_spr_hit = '0, i_spr_bg_hit = '0, i_lp_x = '0;
   logic        o_irq_n;
   logic [6:0]  o_ctrl1, o_mem_ptr;
   logic [8:0]  o_raster_cmp;
   logic [5:0]  o_ctrl2;
   logic [71:0] o_spr_x;
   logic [63:0] o_spr_y;
   logic [7:0]  o_spr_en, o_spr_yexp, o_spr_prio, o_spr_mc, o_spr_xexp;
   logic [3:0]  o_border, o_spr_mc0, o_spr_mc1;
   logic [15:0] o_bg;
   logic [31:0] o_spr_col;

   always #5 clk = ~clk;

   vic_reg_file #(.NUM_SPR(8), .LP_ONCE_PER_FRAME(1'b1)) dut (
      .clk(clk), .reset(reset), .i_bus_ce(i_bus_ce), .i_cs(i_cs), .i_rw(i_rw),
      .i_addr(i_addr), .i_data(i_data), .o_data(o_data), .i_raster_y(i_raster_y),
      .i_line_start(i_line_start), .i_frame_start(i_frame_start),
      .i_spr_spr_hit(i_spr_spr_hit), .i_spr_bg_hit(i_spr_bg_hit),
      .i_lp_trig(i_lp_trig), .i_lp_x(i_lp_x), .o_irq_n(o_irq_n),
      .o_ctrl1(o_ctrl1), .o_raster_cmp(o_raster_cmp), .o_ctrl2(o_ctrl2),
      .o_mem_ptr(o_mem_ptr), .o_spr_x(o_spr_x), .o_spr_y(o_spr_y),
      .o_spr_en(o_spr_en), .o_spr_yexp(o_spr_yexp), .o_spr_prio(o_spr_prio),
      .o_spr_mc(o_spr_mc), .o_spr_xexp(o_spr_xexp), .o_border(o_border),
      .o_bg(o_bg), .o_spr_mc0(o_spr_mc0), .o_spr_mc1(o_spr_mc1),
      .o_spr_col(o_spr_col)
   );

   int errors = 0;
   int checks = 0;
   bit chk_on = 1'b0;

   task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [7:0] m_reg [64];
   logic [7:0] m_ss, m_sb, m_lpx, m_lpy, m_data;
   logic [3:0] m_latch, m_en;
   bit         m_armed;
   logic       m_irq_n;

   function automatic logic [7:0] m_read(input logic [5:0] a);
      if (a >= 6'h2F)                 return 8'hFF;
      if (a >= 6'h20)                 return m_reg[a] | 8'hF0;
      case (a)
         6'h11: return {i_raster_y[8], m_reg[a][6:0]};
         6'h12: return i_raster_y[7:0];
         6'h13: return m_lpx;
         6'h14: return m_lpy;
         6'h16: return m_reg[a] | 8'hC0;
         6'h18: return m_reg[a] | 8'h01;
         6'h19: return {|(m_latch & m_en), 3'b111, m_latch};
         6'h1A: return {4'hF, m_en};
         6'h1E: return m_ss;
         6'h1F: return m_sb;
         default: return m_reg[a];
      endcase
   endfunction

   function automatic bit m_storable(input logic [5:0] a);
      return (a <= 6'h12) || (a >= 6'h15 && a <= 6'h18) ||
             (a >= 6'h1B && a <= 6'h1D) || (a >= 6'h20 && a <= 6'h2E);
   endfunction

   initial begin : model
      logic rd, wr;
      logic [3:0] set, clr;
      logic [7:0] ss_new, sb_new;
      logic [8:0] cmp;
      forever begin
         @(posedge clk or posedge reset);
         if (reset) begin
            for (int i = 0; i < 64; i++) m_reg[i] = 8'h00;
            m_ss = 0; m_sb = 0; m_lpx = 0; m_lpy = 0; m_data = 0;
            m_latch = 0; m_en = 0; m_armed = 1; m_irq_n = 1;
         end else begin
            rd = i_bus_ce && i_cs && i_rw;
            wr = i_bus_ce && i_cs && !i_rw;
            set = 4'h0;
            if (rd) m_data = m_read(i_addr);
            ss_new = ((rd && i_addr == 6'h1E) ? 8'h00 : m_ss) | i_spr_spr_hit;
            sb_new = ((rd && i_addr == 6'h1F) ? 8'h00 : m_sb) | i_spr_bg_hit;
            if (m_ss == 0 && ss_new != 0) set[2] = 1;
            if (m_sb == 0 && sb_new != 0) set[1] = 1;
            cmp = {m_reg[6'h11][7], m_reg[6'h12]};
            if (i_line_start && i_raster_y == cmp) set[0] = 1;
            if (wr && i_addr == 6'h11 && {i_data[7], m_reg[6'h12]} == i_raster_y) set[0] = 1;
            if (wr && i_addr == 6'h12 && {m_reg[6'h11][7], i_data} == i_raster_y) set[0] = 1;
            if (i_frame_start) m_armed = 1;
            if (i_lp_trig && m_armed) begin
               m_lpx = i_lp_x; m_lpy = i_raster_y[7:0]; set[3] = 1; m_armed = 0;
            end
            clr = (wr && i_addr == 6'h19) ? i_data[3:0] : 4'h0;
            m_latch = (m_latch & ~clr) | set;
            if (wr && i_addr == 6'h1A) m_en = i_data[3:0];
            if (wr && m_storable(i_addr)) m_reg[i_addr] = i_data;
            m_ss = ss_new; m_sb = sb_new;
            m_irq_n = !(|(m_latch & m_en));
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin : compare
      logic [71:0] e_x; logic [63:0] e_y; logic [31:0] e_col; logic [15:0] e_bg;
      forever begin
         @(negedge clk);
         if (!reset && chk_on) begin
            for (int n = 0; n < 8; n++) begin
               e_x[9*n +: 9]   = {m_reg[6'h10][n], m_reg[2*n]};
               e_y[8*n +: 8]   = m_reg[2*n+1];
               e_col[4*n +: 4] = m_reg[6'h27+n][3:0];
            end
            for (int n = 0; n < 4; n++) e_bg[4*n +: 4] = m_reg[6'h21+n][3:0];
            chk("o_data", o_data, m_data);
            chk("o_irq_n", o_irq_n, m_irq_n);
            chk("ctrl", {o_ctrl1, o_raster_cmp, o_ctrl2, o_mem_ptr},
                {m_reg[6'h11][6:0], m_reg[6'h11][7], m_reg[6'h12], m_reg[6'h16][5:0], m_reg[6'h18][7:1]});
            chk("spr_bits", {o_spr_en, o_spr_yexp, o_spr_prio, o_spr_mc, o_spr_xexp},
                {m_reg[6'h15], m_reg[6'h17], m_reg[6'h1B], m_reg[6'h1C], m_reg[6'h1D]});
            chk("o_spr_x", o_spr_x, e_x);
            chk("o_spr_y", o_spr_y, e_y);
            chk("colors", {o_border, o_bg, o_spr_mc0, o_spr_mc1, o_spr_col},
                {m_reg[6'h20][3:0], e_bg, m_reg[6'h25][3:0], m_reg[6'h26][3:0], e_col});
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input bit ce, input bit rw, input logic [5:0] a, input logic [7:0] d,
                      input bit line = 1'b0, input bit frame = 1'b0,
                      input logic [7:0] ss = 8'h00, input logic [7:0] sb = 8'h00,
                      input bit lp = 1'b0);
      @(negedge clk);
      i_bus_ce = ce; i_cs = ce; i_rw = rw; i_addr = a; i_data = d;
      i_line_start = line; i_frame_start = frame;
      i_spr_spr_hit = ss; i_spr_bg_hit = sb; i_lp_trig = lp;
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [5:0] a, input logic [7:0] d);
      cyc(1'b1, 1'b0, a, d);
   endtask

   task automatic rd(input logic [5:0] a);
      cyc(1'b1, 1'b1, a, 8'h00);
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 6'h00, 8'h00);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk_on = 1'b1;
      chk("rst irq_n", o_irq_n, 1'b1);
      chk("rst data", o_data, 8'h00);

      wr(6'h20, 8'h05); rd(6'h20);
      chk("rd border", o_data, 8'hF5);
      chk("border", o_border, 4'h5);

      wr(6'h12, 8'h30); wr(6'h11, 8'h9B); wr(6'h1A, 8'h01);
      chk("irq idle", o_irq_n, 1'b1);
      i_raster_y = 9'h130;
      cyc(1'b0, 1'b0, 6'h00, 8'h00, 1'b1);
      chk("raster irq", o_irq_n, 1'b0);
      rd(6'h19); chk("rd irq set", o_data, 8'hF1);
      wr(6'h19, 8'h01); chk("irq cleared", o_irq_n, 1'b1);
      rd(6'h19); chk("rd irq clr", o_data, 8'h70);

      cyc(1'b0, 1'b0, 6'h00, 8'h00, 1'b0, 1'b0, 8'h03);
      rd(6'h1E); chk("coll first", o_data, 8'h03);
      rd(6'h1E); chk("coll cleared", o_data, 8'h00);
      rd(6'h19); chk("mmc latch", o_data, 8'h74);
      cyc(1'b1, 1'b1, 6'h1E, 8'h00, 1'b0, 1'b0, 8'h04);
      chk("coll rd+hit", o_data, 8'h00);
      rd(6'h1E); chk("coll survives", o_data, 8'h04);

      i_lp_x = 8'h40; cyc(1'b0, 1'b0, 6'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
      i_lp_x = 8'h50; cyc(1'b0, 1'b0, 6'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
      rd(6'h13); chk("lp once", o_data, 8'h40);
      rd(6'h14); chk("lp y", o_data, 8'h30);
      cyc(1'b0, 1'b0, 6'h00, 8'h00, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 6'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
      rd(6'h13); chk("lp rearm", o_data, 8'h50);
      rd(6'h19); chk("lp latch", o_data, 8'h7C);
      rd(6'h11); chk("rd ctrl1", o_data, 8'h9B);
      rd(6'h12); chk("rd raster", o_data, 8'h30);

      repeat (3000) begin
         @(negedge clk);
         i_bus_ce = 1'($urandom);
         i_cs = ($urandom % 4) != 0;
         i_rw = 1'($urandom);
         i_addr = 6'($urandom);
         i_data = 8'($urandom);
         i_raster_y = ($urandom % 3 == 0) ? {m_reg[6'h11][7], m_reg[6'h12]} : 9'($urandom);
         i_line_start = ($urandom % 4) == 0;
         i_frame_start = ($urandom % 40) == 0;
         i_spr_spr_hit = ($urandom % 8 == 0) ? 8'($urandom) : 8'h00;
         i_spr_bg_hit = ($urandom % 8 == 0) ? 8'($urandom) : 8'h00;
         i_lp_trig = ($urandom % 6) == 0;
         i_lp_x = 8'($urandom);
      end

      wr(6'h1A, 8'h0F);
      cyc(1'b0, 1'b0, 6'h00, 8'h00, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1);
      chk("pre-rst irq", o_irq_n, 1'b0);
      rd(6'h19); chk("pre-rst rd bit7", o_data[7], 1'b1);

      @(negedge clk);
      i_bus_ce = 1'b1; i_cs = 1'b1; i_rw = 1'b1; i_addr = 6'h19;
      i_line_start = 1'b0; i_frame_start = 1'b0; i_lp_trig = 1'b0;
      i_spr_spr_hit = 8'h00; i_spr_bg_hit = 8'h00;
      #2 reset = 1'b1;
      #1;
      chk("async rst irq_n", o_irq_n, 1'b1);
      chk("async rst data", o_data, 8'h00);
      @(posedge clk);
      @(negedge clk);
      i_bus_ce = 1'b0; i_cs = 1'b0;
      reset = 1'b0;
      chk("rst spr_x", o_spr_x, 72'h0);
      chk("rst colors", {o_border, o_bg, o_spr_mc0, o_spr_mc1, o_spr_col}, 72'h0);
      chk("rst ctrl", {o_ctrl1, o_raster_cmp, o_ctrl2, o_mem_ptr, o_spr_en, o_spr_yexp,
                       o_spr_prio, o_spr_mc, o_spr_xexp}, 72'h0);
      wr(6'h3F, 8'h12); rd(6'h3F);
      chk("unused reg", o_data, 8'hFF);
      idle(); idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vic_reg_file.md
Name: vic_reg_file

Overview:
- CPU-side register responder of the VIC6569 (MOS 6569 VIC-II). The 6510 bus is the initiator; this block is the target.
- Decodes the 64-byte register window at $D000-$D03F. Holds all writable VIC-II registers and returns read data with the chip's unused-bit conventions.
- Latches interrupt sources and drives the CPU IRQ line.
- Sits between the address decoder/bus glue and the video core. The core consumes the register fields and feeds back raster position, collisions and light-pen events.

Parameters:
- NUM_SPR, 8, sprite count; fixed at 8; selects flat-vector widths.
- LP_ONCE_PER_FRAME, 1, 1 = light pen latches only the first trigger per frame.

Ports:
- clk  in  1  system clock, sole clock
- reset  in  1  asynchronous, active-high
- i_bus_ce  in  1  one-clk strobe per phi2 high phase; bus sampled only when high
- i_cs  in  1  chip select; window decoded and mirrored externally
- i_rw  in  1  1 = read, 0 = write
- i_addr  in  6  register index
- i_data  in  8  write data
- o_data  out  8  read data; registered
- i_raster_y  in  9  current raster line
- i_line_start  in  1  one-clk pulse when i_raster_y changes
- i_frame_start  in  1  one-clk pulse at raster line 0
- i_spr_spr_hit  in  8  sprite-sprite collision bits, valid for one clk
- i_spr_bg_hit  in  8  sprite-background collision bits, valid for one clk
- i_lp_trig  in  1  light-pen trigger pulse
- i_lp_x  in  8  raster X/2 at trigger
- o_irq_n  out  1  IRQ to CPU, active-low
- o_ctrl1  out  7  $D011 bits 6:0
- o_raster_cmp  out  9  raster compare value
- o_ctrl2  out  6  $D016 bits 5:0
- o_mem_ptr  out  7  $D018 bits 7:1
- o_spr_x  out  72  8 x 9-bit sprite X; sprite n at [9n+8:9n]
- o_spr_y  out  64  8 x 8-bit sprite Y
- o_spr_en, o_spr_yexp, o_spr_prio, o_spr_mc, o_spr_xexp  out  8 each  $D015, $D017, $D01B, $D01C, $D01D
- o_border  out  4  $D020
- o_bg  out  16  $D021-$D024; bg n at [4n+3:4n]
- o_spr_mc0, o_spr_mc1  out  4 each  $D025, $D026
- o_spr_col  out  32  $D027-$D02E

Behaviour:
- Reset:
  - All registers, latches and o_data are 0.
  - o_irq_n = 1.
  - Light pen is armed.
  - Reset is asynchronous and wins over every other event, including mid-access.
- Access:
  - An access occurs only when i_bus_ce & i_cs.
  - Write (i_rw = 0): register updated on that clk edge; visible on outputs the next cycle.
  - Read (i_rw = 1): o_data loaded on that edge (latency 1); o_data holds between reads.
- Read map (registers not listed read back their full stored value):
  - $11: bit7 = i_raster_y[8], bits 6:0 stored.
  - $12: i_raster_y[7:0].
  - $13/$14: light-pen X/Y.
  - $16: bits 7:6 read 1.
  - $18: bit0 reads 1.
  - $19: bits 6:4 read 1.
  - $1A: bits 7:4 read 1.
  - $20-$2E: bits 7:4 read 1.
  - $2F-$3F: read $FF; writes ignored.
- Raster compare writes:
  - Write $12 sets cmp[7:0].
  - Write $11 sets cmp[8] from data bit7.
  - $13/$14 and $1E/$1F are read-only.
- Interrupt latch ($19):
  - Bit0 RST: set on i_line_start with i_raster_y == cmp. Also set when a write to $11/$12 makes cmp equal to the current i_raster_y.
  - Bit1 MBC: set when $1F goes from zero to nonzero.
  - Bit2 MMC: set when $1E goes from zero to nonzero.
  - Bit3 LP: set on light-pen latch.
  - Writing 1 to a bit clears it. If set and clear hit the same cycle, set wins.
- IRQ:
  - Read bit7 = |(latch & enable[3:0]).
  - o_irq_n = ~bit7, registered; asserts 1 cycle after the cause.
- Collisions:
  - $1E |= i_spr_spr_hit and $1F |= i_spr_bg_hit every clk.
  - A read clears the register.
  - A hit arriving in the read cycle survives: new value = hits only. The read returns the pre-OR value.
- Light pen:
  - i_lp_trig while armed: latch $13 = i_lp_x, $14 = i_raster_y[7:0], set LP, disarm.
  - Re-armed by i_frame_start. Frame start and trigger in the same cycle: re-arm, then latch.
  - With LP_ONCE_PER_FRAME = 0 the block never disarms.

Decomposition:
- Package vic_pkg:
  - Register index constants (REG_CTRL1 = 6'h11 … REG_SPR7_COL = 6'h2E).
  - IRQ bit positions.
  - Unused-bit OR masks per register.
- One sub-module, vic_irq_ctrl: interrupt latch, enable register, collision zero-to-nonzero detection, o_irq_n.

Test Plan:
- Write $20 = $05, then read $20 -> o_data = $F5; o_border = 5.
- Raster IRQ:
  - Write $12 = $30, $11 = $9B, $1A = $01; drive i_raster_y = $130 with i_line_start -> o_irq_n = 0 one cycle later; read $19 = $F1.
  - Write $19 = $01 -> o_irq_n = 1; read $19 = $70.
- Collisions:
  - Pulse i_spr_spr_hit = $03 -> $1E reads $03; a second read gives $00; $19 bit2 set.
  - Read $1E while pulsing $04 -> returns $00; the next read returns $04.
- Light pen:
  - Two i_lp_trig pulses (i_lp_x = $40, then $50) in one frame -> $13 = $40.
  - After i_frame_start, trigger with $50 -> $13 = $50.
- Reset: assert reset mid-read with IRQ pending -> o_irq_n = 1 and o_data = 0 immediately; all register outputs 0; write $3F = $12 -> read $FF.
